ai_compare_scheduler: RTL

//  Sequences the template comparer over NUM_TEMPLATES stored keyword templates for one feature frame.
//  For each template: init pulse, stream FRAME_LEN samples, collect score, track argmin.
//  The error catcher's error flag (comparer buffer overflow) or a watchdog timeout triggers
//  a retry, up to MAX_RETRY retries; after that the template is skipped.

---
 rtl/ai_cmp_pkg.sv | 25 ++
 rtl/ai_compare_best_tracker.sv | 32 +++
 rtl/ai_compare_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ai_cmp_pkg.sv
// Shared types and width helpers for the template-compare scheduler.
// Imported by the scheduler top and the best-score tracker.
package ai_cmp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_STREAM,
      S_WAIT,
      S_NEXT,
      S_FINISH
   } state_t;

   // Cast down to the score width in use.
   localparam logic [63:0] SCORE_MAX = '1;

   function automatic int IDX_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int ADDR_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ai_compare_best_tracker.sv
// Running argmin over template scores.
// Strict less-than, so on ties the earlier (lower) index is kept.
module ai_compare_best_tracker
   import ai_cmp_pkg::*;
#(
   parameter int IW      = 3,
   parameter int SCORE_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               upd,
   input  logic [SCORE_W-1:0] score,
   input  logic [IW-1:0]      idx,
   output logic [IW-1:0]      best_idx,
   output logic [SCORE_W-1:0] best_score
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         best_idx   <= '0;
         best_score <= SCORE_W'(SCORE_MAX);
      end else if (clr) begin
         best_idx   <= '0;
         best_score <= SCORE_W'(SCORE_MAX);
      end else if (upd && (score < best_score)) begin
         best_idx   <= idx;
         best_score <= score;
      end
   end

endmodule

// File: rtl/ai_compare_scheduler.sv
// Walks the comparer over every stored template for one feature frame,
// retrying on error/timeout and tracking the best (lowest) score.
module ai_compare_scheduler
   import ai_cmp_pkg::*;
#(
   parameter  int NUM_TEMPLATES = 8,
   parameter  int FRAME_LEN     = 64,
   parameter  int SCORE_W       = 16,
   parameter  int MAX_RETRY     = 2,
   parameter  int TIMEOUT       = 1024,
   localparam int IW            = IDX_W(NUM_TEMPLATES),
   localparam int AW            = ADDR_W(FRAME_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               cmp_init,
   output logic [IW-1:0]      cmp_tmpl,
   output logic [AW-1:0]      sample_addr,
   output logic               cmp_valid,
   input  logic               cmp_ready,
   input  logic               cmp_done,
   input  logic [SCORE_W-1:0] cmp_score,
   input  logic               cmp_error,
   output logic               done,
   output logic [IW-1:0]      best_idx,
   output logic [SCORE_W-1:0] best_score,
   output logic               fail
);

   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   state_t        state;
   logic [IW-1:0] idx;
   logic [RW-1:0] retry;
   logic [WW-1:0] wd;

   logic xfer;
   logic tmo;
   logic err;
   logic trk_clr;
   logic trk_upd;

   assign cmp_tmpl = idx;
   assign xfer     = cmp_valid & cmp_ready;
   assign tmo      = (state == S_WAIT) && (wd == WW'(TIMEOUT - 1));
   assign err      = ((state == S_STREAM || state == S_WAIT) && cmp_error) || tmo;
   assign trk_clr  = (state == S_IDLE) && start;
   // An error in the same cycle as cmp_done discards that score.
   assign trk_upd  = (state == S_WAIT) && cmp_done && !err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         cmp_init    <= 1'b0;
         cmp_valid   <= 1'b0;
         done        <= 1'b0;
         fail        <= 1'b0;
         sample_addr <= '0;
         idx         <= '0;
         retry       <= '0;
         wd          <= '0;
      end else begin
         cmp_init <= 1'b0;
         done     <= 1'b0;
         if (err) begin
            cmp_valid <= 1'b0;
            if (retry < RW'(MAX_RETRY)) begin
               retry       <= retry + 1'b1;
               cmp_init    <= 1'b1;
               sample_addr <= '0;
               state       <= S_INIT;
            end else begin
               fail  <= 1'b1;
               state <= S_NEXT;
            end
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start) begin
                     busy        <= 1'b1;
                     idx         <= '0;
                     retry       <= '0;
                     fail        <= 1'b0;
                     cmp_init    <= 1'b1;
                     sample_addr <= '0;
                     state       <= S_INIT;
                  end
               end
               S_INIT: begin
                  cmp_valid   <= 1'b1;
                  sample_addr <= '0;
                  state       <= S_STREAM;
               end
               S_STREAM: begin
                  if (xfer) begin
                     if (sample_addr == AW'(FRAME_LEN - 1)) begin
                        cmp_valid <= 1'b0;
                        wd        <= '0;
                        state     <= S_WAIT;
                     end else begin
                        sample_addr <= sample_addr + 1'b1;
                     end
                  end
               end
               S_WAIT: begin
                  if (cmp_done) state <= S_NEXT;
                  else          wd    <= wd + 1'b1;
               end
               S_NEXT: begin
                  if (idx == IW'(NUM_TEMPLATES - 1)) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_FINISH;
                  end else begin
                     idx         <= idx + 1'b1;
                     retry       <= '0;
                     cmp_init    <= 1'b1;
                     sample_addr <= '0;
                     state       <= S_INIT;
                  end
               end
               S_FINISH: state <= S_IDLE;
               default:  state <= S_IDLE;
            endcase
         end
      end
   end

   ai_compare_best_tracker #(
      .IW      (IW),
      .SCORE_W (SCORE_W)
   ) u_best (
      .clk        (clk),
      .rst        (rst),
      .clr        (trk_clr),
      .upd        (trk_upd),
      .score      (cmp_score),
      .idx        (idx),
      .best_idx   (best_idx),
      .best_score (best_score)
   );

endmodule
